// File: rtl/dct_block_scheduler_pkg.sv
// dct_sched_pkg: shared tag types, block-count constants and the block-to-tag mapping
// for dct_block_scheduler.
package dct_sched_pkg;
    typedef enum logic [1:0] {Y = 2'd0, CB = 2'd1, CR = 2'd2} comp_e;

    typedef struct packed {
        comp_e      comp;
        logic [1:0] idx;
        logic       last;
    } tag_t;

    localparam int BLOCKS_422 = 8;
    localparam int BLOCKS_444 = 12;

    // Y0-Y3 come first, then the chroma blocks split evenly between Cb and Cr.
    function automatic tag_t blk_tag(input logic [3:0] n, input logic c444);
        tag_t t;
        t.last = n == (c444 ? 4'd11 : 4'd7);
        if (n < 4'd4) begin
            t.comp = Y;
            t.idx  = n[1:0];
        end else if (c444) begin
            t.comp = n < 4'd8 ? CB : CR;
            t.idx  = n[1:0];
        end else begin
            t.comp = n < 4'd6 ? CB : CR;
            t.idx  = {1'b0, n[0]};
        end
        return t;
    endfunction
endpackage

// File: rtl/dct_tag_fifo.sv
// dct_tag_fifo: tag FIFO for dct blocks in flight; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module dct_tag_fifo
    import dct_sched_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  tag_t i_data,
    input  logic i_pop,
    output tag_t o_data,
    output logic o_full,
    output logic o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr, r_rd;
    tag_t        r_mem [DEPTH];
    logic        w_push, w_pop;

    assign o_empty = r_wr == r_rd;
    assign o_full  = (r_wr - r_rd) == (AW + 1)'(DEPTH);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_wr[AW-1:0] == r_rd[AW-1:0] && o_empty ? r_rd[AW-1:0] : r_rd[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr[AW-1:0]] <= i_data;
                r_wr                <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
        end
    end
endmodule

// File: rtl/dct_block_scheduler.sv
// dct_block_scheduler: issues the blocks of each macroblock to the dct under downstream credit
// control and tags dct outputs. Optional perf counters: DCT_BLOCK_SCHEDULER_PERF_EN.
module dct_block_scheduler
    import dct_sched_pkg::*;
#(
    parameter int CREDITS    = 8,
    parameter int TAG_DEPTH  = 16,
    parameter int CHROMA_444 = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mb_valid,
    output logic        o_mb_ready,
    output logic [3:0]  o_block_sel,
    output logic        o_dct_input_enable,
    input  logic        i_dct_output_enable,
    input  logic        i_credit_return,
    output logic [1:0]  o_out_comp,
    output logic [1:0]  o_out_idx,
    output logic        o_out_last,
    output logic        o_err_underflow,
    output logic [31:0] o_perf_stall_cyc,
    output logic [31:0] o_perf_mb_cnt
);
    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic [3:0] LAST_BLK = 4'((CHROMA_444 != 0 ? BLOCKS_444 : BLOCKS_422) - 1);

    state_t     r_state;
    logic [3:0] r_cnt, r_cred;
    logic       r_err;
    logic       w_full, w_empty, w_pop, w_issue;
    tag_t       w_head;

    assign w_pop   = i_dct_output_enable && !w_empty;
    assign w_issue = !i_rst && r_state == ISSUE && r_cred != 4'd0 && (!w_full || w_pop);

    assign o_mb_ready         = i_rst || r_state == IDLE;
    assign o_block_sel        = i_rst ? 4'd0 : r_cnt;
    assign o_dct_input_enable = w_issue;
    assign {o_out_comp, o_out_idx, o_out_last} = (w_empty || i_rst) ? 5'd0 : w_head;
    assign o_err_underflow    = r_err;

    dct_tag_fifo #(.DEPTH(TAG_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_issue),
        .i_data  (blk_tag(r_cnt, CHROMA_444 != 0)),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_cred  <= 4'(CREDITS);
            r_err   <= 1'b0;
        end else begin
            r_err <= r_err | (i_dct_output_enable & w_empty);
            // an issue and a return in the same cycle cancel out
            if (w_issue && !i_credit_return) r_cred <= r_cred - 4'd1;
            else if (!w_issue && i_credit_return && r_cred != 4'(CREDITS)) r_cred <= r_cred + 4'd1;
            if (r_state == IDLE) begin
                r_cnt <= 4'd0;
                if (i_mb_valid) r_state <= ISSUE;
            end else if (w_issue) begin
                r_cnt <= r_cnt == LAST_BLK ? 4'd0 : r_cnt + 4'd1;
                if (r_cnt == LAST_BLK) r_state <= IDLE;
            end
        end
    end

`ifdef DCT_BLOCK_SCHEDULER_PERF_EN
    logic [31:0] r_stall, r_mbs;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall <= '0;
            r_mbs   <= '0;
        end else begin
            if (r_state == ISSUE && !w_issue && r_stall != '1) r_stall <= r_stall + 32'd1;
            if (r_state == IDLE && i_mb_valid && r_mbs != '1) r_mbs <= r_mbs + 32'd1;
        end
    end

    assign o_perf_stall_cyc = r_stall;
    assign o_perf_mb_cnt    = r_mbs;
`else
    assign o_perf_stall_cyc = '0;
    assign o_perf_mb_cnt    = '0;
`endif
endmodule

// File: doc/dct_block_scheduler.md
DCT_BLOCK_SCHEDULER -- requirements
Module: dct_block_scheduler

Interface
REQ-001 Parameter CREDITS, default 8: downstream block-buffer slots available after reset (1..15).
REQ-002 Parameter TAG_DEPTH, default 16: tag FIFO depth, power of two, not less than the max blocks in flight inside pre_dct+dct.
REQ-003 Parameter CHROMA_444, default 0: 0 = 8 blocks/MB (Y0-Y3, Cb0-Cb1, Cr0-Cr1); 1 = 12 blocks/MB (Y0-Y3, Cb0-Cb3, Cr0-Cr3).
REQ-004 CLOCK  in  1  single clock; all logic on rising edge.
REQ-005 RESET  in  1  synchronous, active-high.
REQ-006 MB_VALID  in  1  macroblock pixels present in the source buffer.
REQ-007 MB_READY  out  1  scheduler accepts the macroblock this cycle.
REQ-008 BLOCK_SEL  out  4  source-buffer block index driving the pre_dct input.
REQ-009 DCT_INPUT_ENABLE  out  1  one-cycle issue strobe to the dct INPUT_DATA_ENABLE.
REQ-010 DCT_OUTPUT_ENABLE  in  1  dct OUTPUT_DATA_ENABLE.
REQ-011 CREDIT_RETURN  in  1  downstream freed one block slot.
REQ-012 OUT_COMP  out  2  component of the current dct output block (0=Y, 1=Cb, 2=Cr).
REQ-013 OUT_IDX  out  2  block index within the component.
REQ-014 OUT_LAST  out  1  last block of the macroblock.
REQ-015 ERR_UNDERFLOW  out  1  sticky: dct output arrived with the tag FIFO empty.
REQ-016 PERF_STALL_CYC, PERF_MB_CNT  out  32 each  performance counters (REQ-034).

Function
REQ-017 State machine: IDLE and ISSUE only.
REQ-018 IDLE: MB_READY=1; MB_VALID=1 -> ISSUE with block counter=0; the handshake completes in the same cycle.
REQ-019 ISSUE: MB_READY=0; one block is issued per cycle when credits>0 and the tag FIFO is not full; otherwise stall with no strobe.
REQ-020 Issue cycle: DCT_INPUT_ENABLE=1, BLOCK_SEL=counter, tag {comp, idx, last} pushed, credit decremented, counter incremented.
REQ-021 Order: the Y blocks, then Cb, then Cr; last=1 on block 7 (or 11 when CHROMA_444=1).
REQ-022 After the last block is issued, return to IDLE; the next MB can be accepted on the following cycle, and the pipeline overlaps MBs.
REQ-023 DCT_OUTPUT_ENABLE=1 pops the tag FIFO; OUT_COMP/OUT_IDX/OUT_LAST show the popped tag in that same cycle (combinational from the FIFO head); the outputs are 0 when the FIFO is empty.
REQ-024 Simultaneous push and pop: both occur, and the occupancy is unchanged; a full FIFO with pop allows the push.
REQ-025 Issue and CREDIT_RETURN in the same cycle: the credit count is unchanged.
REQ-026 CREDIT_RETURN with the count already at CREDITS: ignored, with saturation at CREDITS.
REQ-027 DCT_OUTPUT_ENABLE with the FIFO empty: no pop, ERR_UNDERFLOW set until RESET.
REQ-028 Credit and FIFO pointers wrap modulo their widths; full = occupancy TAG_DEPTH.

Reset
REQ-029 RESET=1 forces state to IDLE, counter 0, credits=CREDITS, FIFO empty, ERR_UNDERFLOW 0, and perf counters 0.
REQ-030 Reset during ISSUE abandons the macroblock; in-flight dct outputs after reset raise ERR_UNDERFLOW.
REQ-031 Output values during and one cycle after reset: MB_READY=1, DCT_INPUT_ENABLE=0, BLOCK_SEL=0, OUT_*=0.

Configuration
REQ-032 Macro DCT_BLOCK_SCHEDULER_PERF_EN selects whether the performance counters are compiled in.
REQ-033 Without the macro: PERF_STALL_CYC and PERF_MB_CNT are tied to 0, and no counter flops are instantiated.
REQ-034 With the macro: PERF_STALL_CYC counts ISSUE cycles without a strobe, PERF_MB_CNT counts accepted MBs, and both counters saturate at 32'hFFFF_FFFF.

Structure
REQ-035 Package dct_sched_pkg holds comp_e (Y, CB, CR), the tag_t struct {comp, idx, last}, and the BLOCKS_422=8 and BLOCKS_444=12 constants.
REQ-036 Sub-module dct_tag_fifo (parameter DEPTH, payload tag_t, with push/pop/full/empty) is instantiated once.

Verification
REQ-037 Scenario 1: one MB with CHROMA_444=0 and dct latency 12 -> strobes on 8 consecutive cycles with BLOCK_SEL 0..7; the outputs give comp Y,Y,Y,Y,Cb,Cb,Cr,Cr, and OUT_LAST=1 only on the 8th.
REQ-038 Scenario 2: CREDITS=3 with no CREDIT_RETURN -> exactly 3 strobes, then a stall; one CREDIT_RETURN gives exactly one more strobe.
REQ-039 Scenario 3: CREDIT_RETURN coincident with an issue at credits=1 -> the count stays 1, and the next cycle issues.
REQ-040 Scenario 4: back-to-back MBs with MB_VALID held high -> 16 strobes with one IDLE gap cycle; the tag order is preserved across the MB boundary.
REQ-041 Scenario 5: RESET pulsed at block 5 -> IDLE, credits restored to 8, and the next dct output pulse sets ERR_UNDERFLOW=1.
REQ-042 Scenario 6: with DCT_BLOCK_SCHEDULER_PERF_EN and CREDITS=2 holding one MB for 10 stall cycles -> PERF_STALL_CYC=10 and PERF_MB_CNT=1; without the macro both are 0.
